// File: rtl/sm_fifo.sv
// State-machine FIFO pair: TX (host -> machine) and RX (machine -> host).
// The two FIFOs can be joined into one double-depth FIFO in either direction.
// Heads are first-word fall-through; error and stall flags are sticky.

// One circular buffer whose capacity is selected at run time (0, DEPTH or 2*DEPTH).
module sm_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(2 * DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [3:0]    cap_i,
  input  logic          wr_i,
  input  logic [31:0]   wdata_i,
  input  logic          rd_i,
  output logic [31:0]   head_o,
  output logic [3:0]    level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          wr_drop_o,
  output logic          rd_rej_o
);
  logic [31:0]   mem_q [2*DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    cap_m1;
  logic          wr_ok, rd_ok;

  // Accept/reject decisions use the level before the edge; pointers wrap at capacity-1.
  always_comb begin
    cap_m1  = cap_i - 4'd1;
    wr_ok   = wr_i && (level_q < cap_i);
    rd_ok   = rd_i && (level_q != 4'd0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = 4'd0;
    end else begin
      if (wr_ok) wptr_d = (wptr_q == cap_m1[PW-1:0]) ? '0 : wptr_q + PW'(1);
      if (rd_ok) rptr_d = (rptr_q == cap_m1[PW-1:0]) ? '0 : rptr_q + PW'(1);
      level_d = level_q + 4'(wr_ok) - 4'(rd_ok);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= 4'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage; wiped on reset so no queued word can reappear afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2 * DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign head_o    = (level_q != 4'd0) ? mem_q[rptr_q] : 32'h0;
  assign level_o   = level_q;
  assign full_o    = (level_q == cap_i);
  assign empty_o   = (level_q == 4'd0);
  assign wr_drop_o = wr_i && !wr_ok;
  assign rd_rej_o  = rd_i && (level_q == 4'd0);
endmodule

// Top level: capacity selection, join-change flush and sticky flags.
module sm_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_en,
  input  logic        pull,
  input  logic        push,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        empty,
  output logic        full,
  input  logic        tx_wr,
  input  logic [31:0] tx_wdata,
  input  logic        rx_rd,
  output logic [31:0] rx_rdata,
  input  logic        join_tx,
  input  logic        join_rx,
  input  logic        clr_flags,
  output logic [3:0]  tx_level,
  output logic [3:0]  rx_level,
  output logic        tx_full,
  output logic        rx_empty,
  output logic        tx_over,
  output logic        rx_under,
  output logic        tx_stall,
  output logic        rx_stall
);
  localparam logic [3:0] CAP1 = 4'(DEPTH);
  localparam logic [3:0] CAP2 = 4'(2 * DEPTH);

  logic       join_tx_q, join_rx_q;
  logic       join_chg;
  logic [3:0] cap_tx, cap_rx;
  logic       tx_drop, tx_rej, rx_drop, rx_rej;
  logic       tx_over_q, rx_under_q, tx_stall_q, rx_stall_q;

  // Capacity follows the registered join setting so it changes together with the flush.
  always_comb begin
    join_chg = (join_tx != join_tx_q) || (join_rx != join_rx_q);
    cap_tx   = CAP1;
    cap_rx   = CAP1;
    if (join_tx_q && !join_rx_q) begin
      cap_tx = CAP2;
      cap_rx = 4'd0;
    end else if (join_rx_q && !join_tx_q) begin
      cap_tx = 4'd0;
      cap_rx = CAP2;
    end
  end

  sm_fifo_buf #(.DEPTH(DEPTH)) u_tx (
    .clk_i(clk), .rst_i(reset), .flush_i(join_chg), .cap_i(cap_tx),
    .wr_i(tx_wr), .wdata_i(tx_wdata), .rd_i(pull && m_en),
    .head_o(m_rdata), .level_o(tx_level), .full_o(tx_full), .empty_o(empty),
    .wr_drop_o(tx_drop), .rd_rej_o(tx_rej)
  );

  sm_fifo_buf #(.DEPTH(DEPTH)) u_rx (
    .clk_i(clk), .rst_i(reset), .flush_i(join_chg), .cap_i(cap_rx),
    .wr_i(push && m_en), .wdata_i(m_wdata), .rd_i(rx_rd),
    .head_o(rx_rdata), .level_o(rx_level), .full_o(full), .empty_o(rx_empty),
    .wr_drop_o(rx_drop), .rd_rej_o(rx_rej)
  );

  // Join tracking and sticky flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      join_tx_q  <= 1'b0;
      join_rx_q  <= 1'b0;
      tx_over_q  <= 1'b0;
      rx_under_q <= 1'b0;
      tx_stall_q <= 1'b0;
      rx_stall_q <= 1'b0;
    end else begin
      join_tx_q  <= join_tx;
      join_rx_q  <= join_rx;
      tx_over_q  <= (tx_over_q  && !clr_flags) || (tx_drop && !join_chg);
      rx_under_q <= (rx_under_q && !clr_flags) || (rx_rej  && !join_chg);
      tx_stall_q <= (tx_stall_q && !clr_flags) || (tx_rej  && !join_chg);
      rx_stall_q <= (rx_stall_q && !clr_flags) || (rx_drop && !join_chg);
    end
  end

  assign tx_over  = tx_over_q;
  assign rx_under = rx_under_q;
  assign tx_stall = tx_stall_q;
  assign rx_stall = rx_stall_q;
endmodule

// File: tb/tb_sm_fifo.sv
// Scoreboard bench for sm_fifo: stimulus updates a queue-based model and pushes
// expectations; a negedge monitor compares status every cycle and data on every pop.
module tb_sm_fifo;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_en = 0, pull = 0, push = 0, tx_wr = 0, rx_rd = 0;
  logic        join_tx = 0, join_rx = 0, clr_flags = 0;
  logic [31:0] m_wdata = 0, tx_wdata = 0;
  logic [31:0] m_rdata, rx_rdata;
  logic        empty, full, tx_full, rx_empty;
  logic [3:0]  tx_level, rx_level;
  logic        tx_over, rx_under, tx_stall, rx_stall;

  sm_fifo #(.DEPTH(D)) dut (
    .clk(clk), .reset(reset), .m_en(m_en), .pull(pull), .push(push),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .empty(empty), .full(full),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
    .join_tx(join_tx), .join_rx(join_rx), .clr_flags(clr_flags),
    .tx_level(tx_level), .rx_level(rx_level), .tx_full(tx_full), .rx_empty(rx_empty),
    .tx_over(tx_over), .rx_under(rx_under), .tx_stall(tx_stall), .rx_stall(rx_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tl, rl;
    logic        e, f, tf, re, ov, un, ts, rs;
    logic [31:0] mh, rh;
  } stat_t;

  // Reference model state
  logic [31:0] txq[$], rxq[$];
  logic [31:0] mq[$], rq[$];
  stat_t       sq[$];
  bit          pjt, pjr;
  bit          m_ov, m_un, m_ts, m_rs;
  bit          cfg_jt, cfg_jr;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int cap_of(input bit is_tx);
    if (pjt && !pjr) return is_tx ? 2 * D : 0;
    if (pjr && !pjt) return is_tx ? 0 : 2 * D;
    return D;
  endfunction

  function automatic stat_t model_stat();
    stat_t s;
    s.tl = 4'(txq.size());
    s.rl = 4'(rxq.size());
    s.e  = (txq.size() == 0);
    s.f  = (rxq.size() == cap_of(0));
    s.tf = (txq.size() == cap_of(1));
    s.re = (rxq.size() == 0);
    s.ov = m_ov; s.un = m_un; s.ts = m_ts; s.rs = m_rs;
    s.mh = (txq.size() > 0) ? txq[0] : 32'h0;
    s.rh = (rxq.size() > 0) ? rxq[0] : 32'h0;
    return s;
  endfunction

  // One clock cycle of stimulus: drive inputs, queue expected status, advance the model.
  task automatic cycle(input bit rst, input bit men, input bit pl, input bit ps,
                       input logic [31:0] mw, input bit tw, input logic [31:0] twd,
                       input bit rr, input bit clr);
    int tn, rn, ct, cr;
    bit tpop, tpush, rpop, rpush;
    @(posedge clk); #2;
    reset = rst; m_en = men; pull = pl; push = ps; m_wdata = mw;
    tx_wr = tw; tx_wdata = twd; rx_rd = rr; clr_flags = clr;
    join_tx = cfg_jt; join_rx = cfg_jr;
    if (rst) begin
      txq.delete(); rxq.delete();
      pjt = 0; pjr = 0;
      m_ov = 0; m_un = 0; m_ts = 0; m_rs = 0;
      #1;
      chk("rst_async_m_rdata", m_rdata, 0);
      chk("rst_async_rx_rdata", rx_rdata, 0);
      chk("rst_async_bits", {empty, rx_empty, full, tx_full}, 4'b1100);
    end
    sq.push_back(model_stat());
    if (rst) return;
    if (cfg_jt != pjt || cfg_jr != pjr) begin
      txq.delete(); rxq.delete();
      pjt = cfg_jt; pjr = cfg_jr;
      if (clr) begin m_ov = 0; m_un = 0; m_ts = 0; m_rs = 0; end
      return;
    end
    tn = txq.size(); rn = rxq.size(); ct = cap_of(1); cr = cap_of(0);
    tpop  = pl && men && tn > 0;
    tpush = tw && tn < ct;
    rpush = ps && men && rn < cr;
    rpop  = rr && rn > 0;
    if (clr) begin m_ov = 0; m_un = 0; m_ts = 0; m_rs = 0; end
    if (pl && men && tn == 0) m_ts = 1;
    if (tw && !tpush) m_ov = 1;
    if (ps && men && !rpush) m_rs = 1;
    if (rr && rn == 0) m_un = 1;
    if (tpop) mq.push_back(txq.pop_front());
    if (tpush) txq.push_back(twd);
    if (rpop) rq.push_back(rxq.pop_front());
    if (rpush) rxq.push_back(mw);
  endtask

  task automatic idle();           cycle(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic twr(input logic [31:0] d); cycle(0, 0, 0, 0, 0, 1, d, 0, 0); endtask
  task automatic mpull();          cycle(0, 1, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic mpush(input logic [31:0] d); cycle(0, 1, 0, 1, d, 0, 0, 0, 0); endtask
  task automatic hrd();            cycle(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic clrf();           cycle(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic rst_cyc();        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Monitor: status every cycle, data whenever the DUT presents an accepted pop.
  always @(negedge clk) begin
    stat_t exp_s, act_s;
    logic [31:0] e;
    if (sq.size() > 0) begin
      exp_s = sq.pop_front();
      act_s = '{tx_level, rx_level, empty, full, tx_full, rx_empty,
                tx_over, rx_under, tx_stall, rx_stall, m_rdata, rx_rdata};
      chk("status", act_s, exp_s);
    end
    if (!reset && pull && m_en && !empty) begin
      if (mq.size() == 0) chk("tx_pop_unexpected", 1, 0);
      else begin
        e = mq.pop_front();
        $display("[TB] tx pop m_rdata=%08h exp=%08h", m_rdata, e);
        chk("tx_pop_data", m_rdata, e);
      end
    end
    if (!reset && rx_rd && !rx_empty) begin
      if (rq.size() == 0) chk("rx_pop_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        $display("[TB] rx pop rx_rdata=%08h exp=%08h", rx_rdata, e);
        chk("rx_pop_data", rx_rdata, e);
      end
    end
  end

  initial begin
    rst_cyc(); rst_cyc(); idle();

    // Fill TX, overflow once, drain in order
    for (int i = 1; i <= 5; i++) twr(32'(i));
    idle();
    chk("fill_tx_level", tx_level, 4);
    chk("fill_tx_full", tx_full, 1);
    chk("fill_tx_over", tx_over, 1);
    for (int i = 0; i < 4; i++) mpull();
    idle();
    chk("drain_empty", empty, 1);
    clrf();

    // pull without m_en does nothing; pull on empty stalls until cleared
    twr(32'hAA); twr(32'hBB);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("no_men_level", tx_level, 2);
    mpull(); mpull(); mpull();
    idle();
    chk("stall_set", tx_stall, 1);
    clrf(); idle();
    chk("stall_clr", tx_stall, 0);

    // Simultaneous write and pop on full, then on level 2
    for (int i = 1; i <= 4; i++) twr(32'h100 + 32'(i));
    cycle(0, 1, 1, 0, 0, 1, 32'h1FF, 0, 0);
    idle();
    chk("wr_rd_full_level", tx_level, 3);
    chk("wr_rd_full_over", tx_over, 1);
    mpull();
    cycle(0, 1, 1, 0, 0, 1, 32'h200, 0, 0);
    idle();
    chk("wr_rd_l2_level", tx_level, 2);
    mpull(); mpull(); clrf();

    // RX joined to 2*DEPTH
    cfg_jr = 1; idle(); idle();
    for (int i = 0; i < 8; i++) mpush(32'hA0 + 32'(i));
    idle();
    chk("join_rx_full", full, 1);
    chk("join_rx_level", rx_level, 8);
    mpush(32'hA8); idle();
    chk("join_rx_stall", rx_stall, 1);
    chk("join_rx_tx_side", {empty, tx_full}, 2'b11);
    for (int i = 0; i < 8; i++) hrd();
    cfg_jr = 0; idle(); clrf();

    // Join toggle flushes both FIFOs; async reset mid-stream
    twr(32'h11); twr(32'h22); twr(32'h33); mpush(32'h44);
    cfg_jt = 1; idle(); idle();
    chk("flush_levels", {tx_level, rx_level}, 8'h00);
    cfg_jt = 0; idle();
    twr(32'h55); twr(32'h66); mpush(32'h77);
    rst_cyc(); idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) rst_cyc();
      else if (r < 4) begin
        cfg_jt = 1'($urandom); cfg_jr = 1'($urandom);
        idle();
      end else
        cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 1) == 0,
              $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    idle();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(mq.size() + rq.size() + sq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sm_fifo.md
SM_FIFO -- requirements
Module: sm_fifo

Interface
REQ-001 Parameter DEPTH, default 4: entries per FIFO when not joined; joined FIFO holds 2*DEPTH.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m_en  input  1  machine clock-enable strobe (en & penable); machine-side push/pull count only when high.
REQ-005 pull  input  1  machine pull request from TX FIFO.
REQ-006 push  input  1  machine push request into RX FIFO.
REQ-007 m_wdata  input  32  machine push data.
REQ-008 m_rdata  output  32  TX head word to machine, first-word fall-through.
REQ-009 empty  output  1  TX FIFO empty, to machine.
REQ-010 full  output  1  RX FIFO full, to machine.
REQ-011 tx_wr  input  1  host write strobe into TX FIFO.
REQ-012 tx_wdata  input  32  host write data.
REQ-013 rx_rd  input  1  host read strobe from RX FIFO.
REQ-014 rx_rdata  output  32  RX head word to host, first-word fall-through.
REQ-015 join_tx, join_rx  input  1 each  join config; only one set = that FIFO is 2*DEPTH and the other is disabled.
REQ-016 clr_flags  input  1  clears all sticky flags.
REQ-017 tx_level, rx_level  output  4 each  current occupancy, 0..2*DEPTH.
REQ-018 tx_full, rx_empty  output  1 each  host-side status.
REQ-019 tx_over, rx_under, tx_stall, rx_stall  output  1 each  sticky error/stall flags.

Function
REQ-020 Each FIFO is a circular buffer with read pointer, write pointer and level counter; pointers wrap modulo current capacity.
REQ-021 Capacity: join_tx&!join_rx -> TX 2*DEPTH, RX 0; join_rx&!join_tx -> RX 2*DEPTH, TX 0; both or neither -> DEPTH each.
REQ-022 A disabled (capacity 0) FIFO reads permanently empty and full; writes dropped with overflow flag set.
REQ-023 Any change of join_tx or join_rx flushes both FIFOs (levels and pointers to 0) on the next clk edge; flags unchanged.
REQ-024 TX write: tx_wr with tx_level < capacity stores tx_wdata, level +1; tx_wr when full drops data, sets tx_over.
REQ-025 TX read: pull & m_en with level > 0 advances read pointer, level -1; pull & m_en when empty sets tx_stall, no state change.
REQ-026 RX write: push & m_en with level < capacity stores m_wdata; push & m_en when full drops data, sets rx_stall.
REQ-027 RX read: rx_rd with level > 0 advances pointer; rx_rd when empty sets rx_under.
REQ-028 Full/empty decisions use pre-edge level: simultaneous write and read on a full FIFO -> read accepted, write dropped with flag; on an empty FIFO -> write accepted, read rejected with flag.
REQ-029 Simultaneous accepted write and read: level unchanged, both pointers advance.
REQ-030 m_rdata/rx_rdata present head word combinationally; 32'h0 when empty.
REQ-031 empty = (tx_level==0); full = (rx_level==capacity_rx); tx_full = (tx_level==capacity_tx); rx_empty = (rx_level==0).
REQ-032 Sticky flags stay set until clr_flags; clr_flags same cycle as a set event -> flag remains set.
REQ-033 Accepted write visible at head on the cycle after the write edge (one-cycle write-to-read latency).

Reset
REQ-034 reset asserted asynchronously clears pointers, levels, all flags; m_rdata=rx_rdata=0, empty=1, rx_empty=1, full=0, tx_full=0.
REQ-035 Reset mid-operation discards all queued data; no stored word survives reset.

Verification
REQ-036 Host writes 1,2,3,4 (DEPTH=4, no join) -> tx_full=1, tx_level=4; 5th write -> tx_over=1, level 4; four pulls with m_en -> m_rdata 1,2,3,4 in order, empty=1.
REQ-037 pull=1, m_en=0 for 10 cycles on non-empty TX -> no pop; pull with m_en on empty TX -> tx_stall=1, clr_flags -> 0.
REQ-038 join_rx=1: machine pushes 8 words A0..A7 -> full=1 after 8th, rx_level=8; 9th -> rx_stall; host reads A0..A7 in order; TX reports empty and tx_full.
REQ-039 TX full, tx_wr and pull with m_en same cycle -> head popped, new word dropped, tx_over=1, level 3; TX level 2, same -> level 2, order preserved.
REQ-040 Three words queued, toggle join_tx -> both levels 0 next cycle; reset asserted mid-stream between edges -> outputs reach reset values without a clock edge.
